// File: rtl/tft_mem_server.sv
// Memory-side responder for the display refill protocol: one request at a time,
// BURST pipelined backend reads forwarded in order, with abort and overrun detection.
module tft_mem_server #(
  parameter int AN     = 24,
  parameter int DN     = 16,
  parameter int BURST  = 8,
  parameter int MAXLAT = 15
) (
  input  logic          clkSYS,
  input  logic          reset,
  input  logic          req,
  input  logic [AN-1:0] req_addr,
  output logic          req_ack,
  input  logic          abort,
  output logic [DN-1:0] mem_data,
  output logic          mem_valid,
  output logic [AN-1:0] bus_addr,
  output logic          bus_rd,
  input  logic          bus_ready,
  input  logic [DN-1:0] bus_rdata,
  input  logic          bus_rvalid,
  output logic          busy,
  output logic          overrun
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] LAST_CMD = CW'(BURST - 1);

  if (BURST < 1 || BURST > 64 || (BURST & (BURST - 1)) != 0 || MAXLAT < 1) begin : g_bad_params
    $error("tft_mem_server: BURST must be a power of two in 1..64 and MAXLAT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [AN-1:0]   base_q, base_d;
  logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [AN-1:0]   bus_addr_q, bus_addr_d;
  logic            bus_rd_q, bus_rd_d;
  logic            req_ack_q, req_ack_d;
  logic            mem_valid_q, mem_valid_d;
  logic [DN-1:0]   mem_data_q, mem_data_d;
  logic            aborted_q, aborted_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;

  logic            accept;
  logic            rv_ok;

  assign accept = bus_rd_q & bus_ready;
  // Returns with nothing outstanding are strays (e.g. after a reset) and never count.
  assign rv_ok  = bus_rvalid & (outstanding_q != '0);

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    issue_cnt_d   = issue_cnt_q;
    bus_rd_d      = bus_rd_q;
    req_ack_d     = 1'b0;
    aborted_d     = aborted_q;

    case ({accept, rv_ok})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    mem_valid_d = rv_ok & ~abort & ~aborted_q;
    mem_data_d  = mem_valid_d ? bus_rdata : mem_data_q;
    overrun_d   = overrun_q | (bus_rvalid & (outstanding_q == '0));

    case (state_q)
      IDLE: begin
        aborted_d = 1'b0;
        bus_rd_d  = 1'b0;
        if (req && !abort) begin
          base_d      = req_addr;
          issue_cnt_d = '0;
          req_ack_d   = 1'b1;
          bus_rd_d    = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
        end
        if (abort) begin
          aborted_d = 1'b1;
          bus_rd_d  = 1'b0;
          state_d   = DRAIN;
        end else if (accept && issue_cnt_q == LAST_CMD) begin
          bus_rd_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        bus_rd_d = 1'b0;
        if (abort) begin
          aborted_d = 1'b1;
        end
        if (outstanding_q == '0 && !bus_rvalid) begin
          aborted_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        bus_rd_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    bus_addr_d = base_d + AN'(issue_cnt_d);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      issue_cnt_q   <= '0;
      outstanding_q <= '0;
      bus_addr_q    <= '0;
      bus_rd_q      <= 1'b0;
      req_ack_q     <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_data_q    <= '0;
      aborted_q     <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      issue_cnt_q   <= issue_cnt_d;
      outstanding_q <= outstanding_d;
      bus_addr_q    <= bus_addr_d;
      bus_rd_q      <= bus_rd_d;
      req_ack_q     <= req_ack_d;
      mem_valid_q   <= mem_valid_d;
      mem_data_q    <= mem_data_d;
      aborted_q     <= aborted_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign mem_valid = mem_valid_q;
  assign mem_data  = mem_data_q;
  assign bus_addr  = bus_addr_q;
  assign bus_rd    = bus_rd_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
